// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the pattern scan controller.
package pattern_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PAT_W = 3;
  localparam logic [DEF_PAT_W-1:0] RST_PATTERN_DEF = 3'b100;
  localparam int NWIN = DEF_WIDTH - DEF_PAT_W + 1;

  function automatic int calc_nwin(input int width, input int pat_w);
    return width - pat_w + 1;
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word/result handshake and pattern configuration bus of the scan controller.
interface pattern_scan_ctrl_if
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PAT_W = DEF_PAT_W
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_match_n;
  logic [2:0]       out_pos;
  logic [2:0]       out_count;

  modport master (
    output cfg_we, cfg_pattern, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_match_n, out_pos, out_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_match_n, out_pos, out_count
  );
endinterface

// File: rtl/pattern_scan_ctrl_window_cmp.sv
// Combinational comparator: one window slice against the latched pattern.
module pattern_window_cmp
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic [PAT_W-1:0] slice_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             hit_o
);
  assign hit_o = (slice_i == pattern_i);
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans one accepted word, one window per clock, and reports first match
// position and total match count through a valid/ready result port.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               PAT_W       = DEF_PAT_W,
  parameter logic [PAT_W-1:0] RST_PATTERN = RST_PATTERN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  pattern_scan_ctrl_if.slave bus
);

  localparam int         NW       = calc_nwin(WIDTH, PAT_W);
  localparam logic [2:0] LAST_IDX = 3'(NW - 1);

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] wpat_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       idx_q;
  logic [2:0]       count_q;
  logic [2:0]       pos_q;
  logic             match_n_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [PAT_W-1:0] win_slice;
  logic             hit;
  logic [2:0]       count_d;
  logic             first_hit_d;

  assign win_slice = data_q[idx_q +: PAT_W];

  pattern_window_cmp #(.PAT_W(PAT_W)) u_cmp (
    .slice_i   (win_slice),
    .pattern_i (wpat_q),
    .hit_o     (hit)
  );

  always_comb begin
    count_d     = count_q + {2'b00, hit};
    first_hit_d = hit & match_n_q;
  end

  // The pattern register is written in any state; a scan only ever sees wpat_q,
  // captured at acceptance, so a coincident write lands on the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= RST_PATTERN;
      wpat_q      <= RST_PATTERN;
      data_q      <= '0;
      idx_q       <= 3'd0;
      count_q     <= 3'd0;
      pos_q       <= 3'd0;
      match_n_q   <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.cfg_we) pat_q <= bus.cfg_pattern;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            wpat_q     <= pat_q;
            idx_q      <= 3'd0;
            count_q    <= 3'd0;
            pos_q      <= 3'd0;
            match_n_q  <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          count_q <= count_d;
          if (first_hit_d) begin
            match_n_q <= 1'b0;
            pos_q     <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_REPORT;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        ST_REPORT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_match_n = match_n_q;
  assign bus.out_pos     = pos_q;
  assign bus.out_count   = count_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed cases plus randomized words against a
// behavioural model of the scan result and handshake timing.
module tb_pattern_scan_ctrl;
  import pattern_scan_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int PAT_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.WIDTH(WIDTH), .PAT_W(PAT_W)) bus ();

  pattern_scan_ctrl #(.WIDTH(WIDTH), .PAT_W(PAT_W), .RST_PATTERN(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Result of scanning word d with pattern p, straight from the window rule.
  task automatic refm(input logic [WIDTH-1:0] d, input logic [PAT_W-1:0] p,
                      output bit mn, output int pos, output int cnt);
    mn = 1'b1; pos = 0; cnt = 0;
    for (int w = 0; w <= WIDTH - PAT_W; w++) begin
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < PAT_W; k++) if (d[w+k] != p[k]) ok = 1'b0;
      if (ok) begin
        cnt++;
        if (mn) begin mn = 1'b0; pos = w; end
      end
    end
  endtask

  // Model: a word is busy for NWIN edges after acceptance, then reported.
  logic [PAT_W-1:0] m_pat = 3'b100;
  bit m_in_ready = 1'b1, m_out_valid = 1'b0, m_busy = 1'b0, m_mn = 1'b1;
  int m_edges = 0, m_pos = 0, m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pat <= 3'b100; m_in_ready <= 1'b1; m_out_valid <= 1'b0; m_busy <= 1'b0;
      m_edges <= 0; m_mn <= 1'b1; m_pos <= 0; m_cnt <= 0;
    end else begin
      bit mn; int p; int c;
      if (bus.cfg_we) m_pat <= bus.cfg_pattern;
      if (m_in_ready && bus.in_valid) begin
        refm(bus.in_data, m_pat, mn, p, c);
        m_mn <= mn; m_pos <= p; m_cnt <= c;
        m_in_ready <= 1'b0; m_busy <= 1'b1; m_edges <= 0;
      end else if (m_busy) begin
        if (m_edges + 1 == NWIN) begin m_busy <= 1'b0; m_out_valid <= 1'b1; end
        m_edges <= m_edges + 1;
      end else if (m_out_valid && bus.out_ready) begin
        m_out_valid <= 1'b0; m_in_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, m_in_ready);
    chk("out_valid", bus.out_valid, m_out_valid);
    if (m_out_valid || !rst_n) begin
      chk("out_match_n", bus.out_match_n, m_mn);
      chk("out_pos", bus.out_pos, m_pos);
      chk("out_count", bus.out_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [WIDTH-1:0] d, input bit we, input logic [PAT_W-1:0] wp);
    int g;
    g = 0;
    while (!bus.in_ready && g < 100) begin tick(); g++; end
    chk("accept_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = d; bus.cfg_we = we; bus.cfg_pattern = wp;
    tick();
    bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin tick(); lat++; end
    chk("result_timeout", bus.out_valid, 1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic word_lit(input string nm, input logic [WIDTH-1:0] d, input bit we,
                          input logic [PAT_W-1:0] wp, input int emn, input int epos, input int ecnt);
    int lat;
    accept(d, we, wp);
    wait_result(lat);
    chk({nm, "_latency"}, lat, 6);
    chk({nm, "_match_n"}, bus.out_match_n, emn);
    chk({nm, "_pos"}, bus.out_pos, epos);
    chk({nm, "_count"}, bus.out_count, ecnt);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mn; int p; int c; int lat;
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;

    refm(8'b0000_0100, 3'b100, mn, p, c);
    chk("model_a_mn", mn, 0); chk("model_a_pos", p, 0); chk("model_a_cnt", c, 1);
    refm(8'b1001_0010, 3'b100, mn, p, c);
    chk("model_b_mn", mn, 0); chk("model_b_pos", p, 2); chk("model_b_cnt", c, 2);
    refm(8'hFF, 3'b111, mn, p, c);
    chk("model_c_cnt", c, 6);
    refm(8'hFF, 3'b100, mn, p, c);
    chk("model_d_mn", mn, 1);

    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_match_n", bus.out_match_n, 1);
    chk("rst_count", bus.out_count, 0);
    rst_n = 1'b1;
    tick();

    word_lit("single", 8'b0000_0100, 1'b0, 3'b000, 0, 0, 1);
    word_lit("double", 8'b1001_0010, 1'b0, 3'b000, 0, 2, 2);
    word_lit("nomatch", 8'hFF, 1'b0, 3'b000, 1, 0, 0);
    bus.cfg_we = 1'b1; bus.cfg_pattern = 3'b111;
    tick();
    bus.cfg_we = 1'b0;
    word_lit("allones", 8'hFF, 1'b0, 3'b000, 0, 0, 6);

    accept(8'h07, 1'b0, 3'b000);
    wait_result(lat);
    bus.in_valid = 1'b1; bus.in_data = 8'hE0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_match_n", bus.out_match_n, 0);
      chk("stall_pos", bus.out_pos, 0);
      chk("stall_count", bus.out_count, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("second_accepted", bus.in_ready, 0);
    wait_result(lat);
    chk("second_latency", lat, 6);
    chk("second_pos", bus.out_pos, 5);
    chk("second_count", bus.out_count, 1);
    consume();

    accept(8'b0000_0100, 1'b0, 3'b000);
    tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_valid", bus.out_valid, 0);
    end
    word_lit("after_rst", 8'b1001_0010, 1'b0, 3'b000, 0, 2, 2);

    word_lit("cfg_same_edge", 8'b0000_0100, 1'b1, 3'b010, 0, 0, 1);
    word_lit("cfg_next_word", 8'b0000_0100, 1'b0, 3'b000, 0, 1, 1);

    for (int n = 0; n < 60; n++) begin
      accept(8'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom));
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
        bus.cfg_we = ($urandom_range(0, 4) == 0);
        bus.cfg_pattern = 3'($urandom);
        tick();
        lat++;
      end
      bus.cfg_we = 1'b0;
      chk("rnd_latency", lat, 6);
      repeat ($urandom_range(0, 3)) tick();
      consume();
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: scanned word width.
REQ-002 SHALL have parameter PAT_W, default 3: pattern (window) width.
REQ-003 SHALL have parameter RST_PATTERN, default 3'b100: pattern register value after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we  input  1  pattern write strobe.
REQ-007 SHALL have port cfg_pattern  input  PAT_W  new pattern value.
REQ-008 SHALL have port in_valid  input  1  word offered.
REQ-009 SHALL have port in_ready  output  1  controller can accept a word.
REQ-010 SHALL have port in_data  input  WIDTH  word to scan.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port out_match_n  output  1  active-low: 0 means at least one match.
REQ-014 SHALL have port out_pos  output  3  index of the lowest matching window.
REQ-015 SHALL have port out_count  output  3  number of matching windows, 0..WIDTH-PAT_W+1.

Function
REQ-016 SHALL implement the FSM states IDLE, SCAN and REPORT.
REQ-017 SHALL, in IDLE, drive in_ready=1; on in_valid&in_ready, latch in_data and the pattern register into working copies, set idx=0, count=0, match_n=1, pos=0, and go to SCAN.
REQ-018 SHALL, in SCAN, evaluate exactly one window per clock: window idx matches when data[idx+k]==pattern[k] for all k in 0..PAT_W-1.
REQ-019 SHALL, on a match, increment count; on the first match of the word only, set match_n=0 and pos=idx.
REQ-020 SHALL move SCAN to REPORT after idx=WIDTH-PAT_W (idx 5 at defaults); the scan has no early exit, so latency is fixed.
REQ-021 SHALL, with an accept edge E0, evaluate windows on edges E1..E6 (defaults) and drive out_valid=1 immediately after E6.
REQ-022 SHALL, in REPORT, hold out_valid and all result outputs stable until out_ready=1; on that edge return to IDLE.
REQ-023 SHALL drive in_ready=0 in SCAN and REPORT; words are never accepted while a scan or result is pending.
REQ-024 SHALL make out_match_n, out_pos and out_count don't-care-free: when no window matches, they SHALL read 1, 0 and 0.
REQ-025 SHALL apply cfg_we in any state, updating only the pattern register; an in-flight scan keeps its latched pattern.
REQ-026 SHALL, when cfg_we and acceptance coincide, scan the accepted word with the pre-write pattern; the new pattern applies from the next word.
REQ-027 SHALL not overflow out_count: the maximum WIDTH-PAT_W+1 (6) fits in 3 bits.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: state=IDLE, pattern=RST_PATTERN, idx=0, count=0, out_valid=0, out_match_n=1, out_pos=0, out_count=0; in_ready SHALL then read 1.
REQ-029 SHALL discard any scan or unconsumed result when reset asserts mid-operation; the first word after release starts a fresh scan.

Structure
REQ-030 SHALL place the FSM state encoding, the RST_PATTERN default and the derived constant NWIN=WIDTH-PAT_W+1 in a shared package.
REQ-031 SHALL contain one sub-module, pattern_window_cmp: a combinational comparator taking a PAT_W-bit slice and the pattern, producing a single hit bit.

Verification
REQ-032 SHALL check: reset, pattern 100, in_data=8'b0000_0100 -> out_match_n=0, out_pos=0, out_count=1, out_valid 6 edges after accept.
REQ-033 SHALL check: in_data=8'b1001_0010 -> out_match_n=0, out_pos=2, out_count=2.
REQ-034 SHALL check: in_data=8'hFF with pattern 100 -> out_match_n=1, out_pos=0, out_count=0; then cfg_we with 3'b111 and 8'hFF -> out_pos=0, out_count=6.
REQ-035 SHALL check: out_ready held 0 for 10 cycles -> outputs stable, in_ready=0, a second in_valid not accepted; accepted one cycle after out_ready.
REQ-036 SHALL check: rst_n pulsed low at the 3rd SCAN cycle -> out_valid never rises for that word; the next word yields a correct result.
REQ-037 SHALL check: cfg_we=3'b010 on the same edge as accepting 8'b0000_0100 -> result uses 100 (pos 0, count 1); the next word scans with 010.
